pc_unit: RTL and testbench
==========================

# pc_unit

Sequential fetch-address unit for the pipelined MIPS CPU, sitting between the D-stage branch/jump decode and the instruction-memory port. It owns the F-stage PC register, selects the next PC among sequential, branch, jump, register-jump, exception and return targets, and handshakes with instruction memory. Redirects that arrive while memory is not ready are held in a pending slot and applied on the next accepted fetch. Address width and vectors are parametrised.

## Interface
- ADDR_W, 32, PC width; legal range 29..32
- RESET_VEC, 32'h0000_3000, PC after reset (low ADDR_W bits used)
- EXC_VEC, 32'h0000_4180, exception handler entry

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  pipeline hazard stall; PC must not advance
- imem_req  out  1  fetch request valid
- imem_ready  in  1  memory accepts `pc` this cycle
- pc  out  ADDR_W  current fetch address
- pc4  out  ADDR_W  pc + 4
- d_pc  in  ADDR_W  PC of instruction in D
- d_instr  in  32  instruction in D
- ifj / ifjr / ifb  in  1 each  D instr is j/jal, jr/jalr, conditional branch
- branch  in  1  branch condition true
- jr_target  in  ADDR_W  forwarded register value for jr
- exc_req  in  1  one-cycle exception pulse
- eret_req  in  1  one-cycle eret pulse
- epc  in  ADDR_W  return address for eret
- redirect_taken  out  1  one-cycle pulse: PC loaded with non-sequential target
- adel  out  1  fetch address misaligned (pc[1:0] != 0)

## Operation
- accept = imem_req && imem_ready && !stall.
- Target priority: exc_req -> EXC_VEC; eret_req -> epc; ifjr -> jr_target; ifj -> {d_pc[ADDR_W-1:28], d_instr[25:0], 2'b00}; ifb&&branch -> d_pc + 4 + (sext(d_instr[15:0]) << 2), truncated mod 2^ADDR_W; else sequential pc4.
- D redirect (ifjr/ifj/ifb&&branch) counted only when stall = 0; under stall D re-presents it.
- exc_req/eret_req always captured, regardless of stall or imem_ready.
- States: RUN (no pending), PEND (pend_target valid).
  - RUN, redirect, accept: pc <= target, redirect_taken = 1, stay RUN.
  - RUN, redirect, !accept: pend_target <= target, go PEND; pc holds.
  - RUN, no redirect, accept: pc <= pc4.
  - PEND, accept: pc <= pend_target, redirect_taken = 1, go RUN.
  - PEND, exc_req/eret_req: pend_target overwritten (exc over eret); D redirects ignored in PEND.
  - exc_req/eret_req with accept in PEND: new target wins, go RUN.
- adel = |pc[1:0]; combinational from pc; PC still fetched, trap raised downstream.
- Wrap-around: pc4 of all-ones-aligned PC wraps to 0, no flag.

## Timing
- Reset (async assert): pc = RESET_VEC, state RUN, pend_target = 0, imem_req = 0, redirect_taken = 0, adel = 0.
- imem_req registered: 0 in first cycle after rst_n deassert, 1 from second cycle onward.
- Redirect-to-pc latency: 1 clock when accepted same cycle; else first accepting edge.
- redirect_taken asserted in the cycle after the loading edge, for exactly one cycle.
- pc4 and adel combinational from pc register; no input-to-output combinational path except none (all outputs registered or derived from registers).
- Reset mid-PEND discards pending target.

## Configuration
- PC_EXC_EN: defined -> exception/eret paths as above. Undefined -> exc_req, eret_req, epc ignored (ports remain, tied off internally), EXC_VEC unused; priority starts at ifjr.

## Test plan
- Reset, release rst_n, imem_ready = 1 -> pc 0x3000, imem_req 0 then 1, pc 0x3004, 0x3008 on following edges.
- d_pc 0x3010, ifb=1, branch=1, imm 0xFFFC, accept -> pc 0x3004 next edge, redirect_taken pulse 1 cycle.
- ifj with d_pc 0x3010, instr[25:0]=0x0000C40, imem_ready=0 two cycles -> PEND; on ready pc = 0x3100, redirect_taken once.
- PEND holding 0x3100, exc_req pulse with stall=1 (PC_EXC_EN) -> after stall drops and accept, pc = 0x4180.
- stall = 1 with ifjr, jr_target 0x5000 for 3 cycles -> pc holds; stall drops -> pc 0x5000.
- eret_req, epc 0x3022 -> pc 0x3022, adel = 1; without PC_EXC_EN same stimulus -> pc sequential.

Source files
------------

// File: rtl/pc_unit.sv
// F-stage fetch-address unit: owns the PC, selects the next fetch target and holds redirects that arrive while imem stalls.
// Optional macro PC_EXC_EN enables the exception / eret redirect paths.
module pc_unit #(
    parameter int unsigned ADDR_W    = 32,
    parameter logic [31:0] RESET_VEC = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC   = 32'h0000_4180
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    output logic              imem_req,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc4,
    input  logic [ADDR_W-1:0] d_pc,
    input  logic [31:0]       d_instr,
    input  logic              ifj,
    input  logic              ifjr,
    input  logic              ifb,
    input  logic              branch,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic              exc_req,
    input  logic              eret_req,
    input  logic [ADDR_W-1:0] epc,
    output logic              redirect_taken,
    output logic              adel
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_q, pend_d;
    logic              imem_req_q;
    logic              redirect_q, redirect_d;

    logic              exc_s, eret_s, trap_s;
    logic [ADDR_W-1:0] epc_s;
    logic [ADDR_W-1:0] pc4_s, br_target_s, j_target_s;
    logic [ADDR_W-1:0] trap_target_s, d_target_s, run_target_s;
    logic              d_redir_s, accept_s;
    logic              unused_op_s;

`ifdef PC_EXC_EN
    assign exc_s  = exc_req;
    assign eret_s = eret_req;
    assign epc_s  = epc;
`else
    logic unused_trap_s;
    assign exc_s         = 1'b0;
    assign eret_s        = 1'b0;
    assign epc_s         = {ADDR_W{1'b0}};
    assign unused_trap_s = ^{exc_req, eret_req, epc};
`endif

    assign unused_op_s = ^d_instr[31:26];
    assign trap_s      = exc_s | eret_s;
    assign accept_s    = imem_req_q & imem_ready & ~stall;
    assign pc4_s       = pc_q + {{(ADDR_W-3){1'b0}}, 3'd4};
    assign j_target_s  = {d_pc[ADDR_W-1:28], d_instr[25:0], 2'b00};
    // Branch offset is relative to the delay-slot address; overflow wraps.
    assign br_target_s = d_pc + {{(ADDR_W-3){1'b0}}, 3'd4}
                       + {{(ADDR_W-18){d_instr[15]}}, d_instr[15:0], 2'b00};
    // A stalled D stage will re-present its redirect, so it is not taken now.
    assign d_redir_s   = ~stall & (ifjr | ifj | (ifb & branch));

    // Target selection: exception over eret over D-stage redirects.
    always_comb begin
        trap_target_s = exc_s ? EXC_VEC[ADDR_W-1:0] : epc_s;
        if (ifjr) begin
            d_target_s = jr_target;
        end else if (ifj) begin
            d_target_s = j_target_s;
        end else begin
            d_target_s = br_target_s;
        end
        run_target_s = trap_s ? trap_target_s : d_target_s;
    end

    // Next-state logic for the RUN/PEND redirect holder and the PC.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        redirect_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (trap_s || d_redir_s) begin
                    if (accept_s) begin
                        pc_d       = run_target_s;
                        redirect_d = 1'b1;
                    end else begin
                        pend_d  = run_target_s;
                        state_d = ST_PEND;
                    end
                end else if (accept_s) begin
                    pc_d = pc4_s;
                end else begin
                    pc_d = pc_q;
                end
            end
            ST_PEND: begin
                if (accept_s) begin
                    pc_d       = trap_s ? trap_target_s : pend_q;
                    redirect_d = 1'b1;
                    state_d    = ST_RUN;
                end else if (trap_s) begin
                    pend_d = trap_target_s;
                end else begin
                    pend_d = pend_q;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State, PC and handshake registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_VEC[ADDR_W-1:0];
            pend_q     <= {ADDR_W{1'b0}};
            imem_req_q <= 1'b0;
            redirect_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            imem_req_q <= 1'b1;
            redirect_q <= redirect_d;
        end
    end

    assign pc             = pc_q;
    assign pc4            = pc4_s;
    assign adel           = |pc_q[1:0];
    assign imem_req       = imem_req_q;
    assign redirect_taken = redirect_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit; exception/eret steps follow PC_EXC_EN.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] pc, pc4;
    logic [31:0] d_pc;
    logic [31:0] d_instr;
    logic        ifj, ifjr, ifb, branch;
    logic [31:0] jr_target;
    logic        exc_req, eret_req;
    logic [31:0] epc;
    logic        redirect_taken;
    logic        adel;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef PC_EXC_EN
    localparam logic [31:0] BASE_PC = 32'h0000_4180;
`else
    localparam logic [31:0] BASE_PC = 32'h0000_3104;
`endif

    pc_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .imem_req       (imem_req),
        .imem_ready     (imem_ready),
        .pc             (pc),
        .pc4            (pc4),
        .d_pc           (d_pc),
        .d_instr        (d_instr),
        .ifj            (ifj),
        .ifjr           (ifjr),
        .ifb            (ifb),
        .branch         (branch),
        .jr_target      (jr_target),
        .exc_req        (exc_req),
        .eret_req       (eret_req),
        .epc            (epc),
        .redirect_taken (redirect_taken),
        .adel           (adel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1; stall = 1'b0; imem_ready = 1'b1;
        d_pc = 32'h0; d_instr = 32'h0; ifj = 1'b0; ifjr = 1'b0; ifb = 1'b0; branch = 1'b0;
        jr_target = 32'h0; exc_req = 1'b0; eret_req = 1'b0; epc = 32'h0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_pc", pc, 32'h0000_3000);
        chk("rst_pc4", pc4, 32'h0000_3004);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_rt", {31'd0, redirect_taken}, 32'd0);
        chk("rst_adel", {31'd0, adel}, 32'd0);
        tick();
        rst_n = 1'b1;
        chk("req_first", {31'd0, imem_req}, 32'd0);
        tick();
        chk("req_on", {31'd0, imem_req}, 32'd1);
        chk("pc_hold_noreq", pc, 32'h0000_3000);
        tick();
        chk("seq1", pc, 32'h0000_3004);
        tick();
        chk("seq2", pc, 32'h0000_3008);

        // backward branch, accepted immediately
        d_pc = 32'h0000_3010; d_instr = 32'h1000_FFFC; ifb = 1'b1; branch = 1'b1;
        tick();
        chk("br_pc", pc, 32'h0000_3004);
        chk("br_rt", {31'd0, redirect_taken}, 32'd1);
        ifb = 1'b0; branch = 1'b0;
        tick();
        chk("br_seq", pc, 32'h0000_3008);
        chk("br_rt_off", {31'd0, redirect_taken}, 32'd0);

        // jump while memory not ready -> pending; jr during pending ignored
        d_instr = 32'h0800_0C40; ifj = 1'b1; imem_ready = 1'b0;
        tick();
        chk("pend_hold1", pc, 32'h0000_3008);
        chk("pend_rt1", {31'd0, redirect_taken}, 32'd0);
        ifj = 1'b0; ifjr = 1'b1; jr_target = 32'h0000_7000;
        tick();
        chk("pend_hold2", pc, 32'h0000_3008);
        imem_ready = 1'b1;
        tick();
        chk("pend_apply", pc, 32'h0000_3100);
        chk("pend_rt", {31'd0, redirect_taken}, 32'd1);
        ifjr = 1'b0;
        tick();
        chk("pend_seq", pc, 32'h0000_3104);
        chk("pend_rt_off", {31'd0, redirect_taken}, 32'd0);

`ifdef PC_EXC_EN
        // exception overwrites a pending jump while stalled
        ifj = 1'b1; imem_ready = 1'b0;
        tick();
        chk("exc_pend", pc, 32'h0000_3104);
        ifj = 1'b0; stall = 1'b1; exc_req = 1'b1; imem_ready = 1'b1;
        tick();
        chk("exc_stall1", pc, 32'h0000_3104);
        exc_req = 1'b0;
        tick();
        chk("exc_stall2", pc, 32'h0000_3104);
        stall = 1'b0;
        tick();
        chk("exc_pc", pc, 32'h0000_4180);
        chk("exc_rt", {31'd0, redirect_taken}, 32'd1);
`endif

        // jr under stall: PC holds, taken once stall drops
        stall = 1'b1; ifjr = 1'b1; jr_target = 32'h0000_5000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("jr_stall_pc", pc, BASE_PC);
            chk("jr_stall_rt", {31'd0, redirect_taken}, 32'd0);
        end
        stall = 1'b0;
        tick();
        chk("jr_pc", pc, 32'h0000_5000);
        chk("jr_rt", {31'd0, redirect_taken}, 32'd1);
        ifjr = 1'b0;
        tick();
        chk("jr_seq", pc, 32'h0000_5004);

        // eret to a misaligned return address
        eret_req = 1'b1; epc = 32'h0000_3022;
        tick();
        eret_req = 1'b0;
`ifdef PC_EXC_EN
        chk("eret_pc", pc, 32'h0000_3022);
        chk("eret_adel", {31'd0, adel}, 32'd1);
        chk("eret_pc4", pc4, 32'h0000_3026);
        chk("eret_rt", {31'd0, redirect_taken}, 32'd1);
`else
        chk("eret_pc", pc, 32'h0000_5008);
        chk("eret_adel", {31'd0, adel}, 32'd0);
        chk("eret_rt", {31'd0, redirect_taken}, 32'd0);
`endif

        // wrap-around of the top aligned address
        ifjr = 1'b1; jr_target = 32'hFFFF_FFFC;
        tick();
        ifjr = 1'b0;
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", pc4, 32'h0000_0000);
        tick();
        chk("wrap_seq", pc, 32'h0000_0000);
        chk("wrap_adel", {31'd0, adel}, 32'd0);

        // reset while a redirect is pending discards it
        d_pc = 32'h0000_3010; d_instr = 32'h0800_0C40; ifj = 1'b1; imem_ready = 1'b0;
        tick();
        ifj = 1'b0;
        chk("rpend_hold", pc, 32'h0000_0000);
        rst_n = 1'b0;
        #1;
        chk("rpend_pc", pc, 32'h0000_3000);
        chk("rpend_req", {31'd0, imem_req}, 32'd0);
        rst_n = 1'b1; imem_ready = 1'b1;
        tick();
        chk("rpend_first", pc, 32'h0000_3000);
        tick();
        chk("rpend_seq", pc, 32'h0000_3004);
        chk("rpend_rt", {31'd0, redirect_taken}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
